// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters and the central arbiter.
// The arbiter connects through the slave modport; the master modport is the requester-side view.
interface bus_arbiter_if #(
   parameter int SLAVE_LEN = 2
);
   logic                      m1_request;
   logic                      m2_request;
   logic                      m1_slave_select;
   logic                      m2_slave_select;
   logic                      m1_done;
   logic                      m2_done;
   logic                      m1_grant;
   logic                      m2_grant;
   logic                      busy;
   logic                      master_sel;
   logic [2**SLAVE_LEN-1:0]   slave_en;
   logic                      timeout;

   modport master (
      output m1_request, m2_request, m1_slave_select, m2_slave_select, m1_done, m2_done,
      input  m1_grant, m2_grant, busy, master_sel, slave_en, timeout
   );

   modport slave (
      input  m1_request, m2_request, m1_slave_select, m2_slave_select, m1_done, m2_done,
      output m1_grant, m2_grant, busy, master_sel, slave_en, timeout
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for two serial-bus masters: grants ownership, shifts in the
// owner's slave-select field, drives one-hot slave enables and guards tenure with a watchdog.
module bus_arbiter #(
   parameter int SLAVE_LEN   = 2,
   parameter int TIMEOUT_LEN = 12,
   parameter int TIMEOUT     = 4095
) (
   input logic         clk,
   input logic         reset,
   bus_arbiter_if.slave bus
);
   localparam int NUM_SLAVES = 2**SLAVE_LEN;
   localparam int CNT_W      = $clog2(SLAVE_LEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      ACTIVE,
      RELEASE
   } state_e;

   state_e                  state_q, state_d;
   logic                    owner_q, owner_d;            // 0 = master 1, 1 = master 2
   logic                    last_owner_q, last_owner_d;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [SLAVE_LEN-1:0]    shift_q, shift_d;
   logic [TIMEOUT_LEN-1:0]  wd_q, wd_d;

   logic                    m1_grant_q, m1_grant_d;
   logic                    m2_grant_q, m2_grant_d;
   logic                    busy_q, busy_d;
   logic                    master_sel_q, master_sel_d;
   logic [NUM_SLAVES-1:0]   slave_en_q, slave_en_d;
   logic                    timeout_q, timeout_d;

   logic own_req, own_done, own_sel, bus_on;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      wd_d         = wd_q;
      timeout_d    = 1'b0;

      own_req  = owner_q ? bus.m2_request      : bus.m1_request;
      own_done = owner_q ? bus.m2_done         : bus.m1_done;
      own_sel  = owner_q ? bus.m2_slave_select : bus.m1_slave_select;

      unique case (state_q)
         IDLE: begin
            if (bus.m1_request || bus.m2_request) begin
               state_d   = SELECT;
               bit_cnt_d = '0;
               shift_d   = '0;
               // On contention the master that did not own the bus last time wins.
               owner_d   = (bus.m1_request && bus.m2_request) ? ~last_owner_q : bus.m2_request;
            end
         end
         SELECT: begin
            if (!own_req || own_done) begin
               state_d = RELEASE;
            end else begin
               if (bit_cnt_q != '0) shift_d = (shift_q << 1) | SLAVE_LEN'(own_sel);
               if (bit_cnt_q == CNT_W'(SLAVE_LEN)) begin
                  state_d = ACTIVE;
                  wd_d    = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         ACTIVE: begin
            if (!own_req || own_done) begin
               state_d = RELEASE;
            end else if (wd_q == TIMEOUT_LEN'(TIMEOUT - 1)) begin
               state_d   = RELEASE;
               timeout_d = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         RELEASE: begin
            state_d      = IDLE;
            last_owner_d = owner_q;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next-state view so they change on the same edge as the state.
      bus_on       = (state_d == SELECT) || (state_d == ACTIVE);
      m1_grant_d   = bus_on && !owner_d;
      m2_grant_d   = bus_on && owner_d;
      busy_d       = bus_on;
      master_sel_d = bus_on && owner_d;
      slave_en_d   = (state_d == ACTIVE) ? (NUM_SLAVES'(1) << shift_d) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         wd_q         <= '0;
         m1_grant_q   <= 1'b0;
         m2_grant_q   <= 1'b0;
         busy_q       <= 1'b0;
         master_sel_q <= 1'b0;
         slave_en_q   <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         wd_q         <= wd_d;
         m1_grant_q   <= m1_grant_d;
         m2_grant_q   <= m2_grant_d;
         busy_q       <= busy_d;
         master_sel_q <= master_sel_d;
         slave_en_q   <= slave_en_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.m1_grant   = m1_grant_q;
   assign bus.m2_grant   = m2_grant_q;
   assign bus.busy       = busy_q;
   assign bus.master_sel = master_sel_q;
   assign bus.slave_en   = slave_en_q;
   assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a tenure-level model of the arbiter.
module tb_bus_arbiter;
   localparam int SL = 2;
   localparam int TO = 8;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   bus_arbiter_if #(.SLAVE_LEN(SL)) bus_if ();

   bus_arbiter #(.SLAVE_LEN(SL), .TIMEOUT_LEN(12), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Tenure model: owner (0 none, 1/2 master), age = cycles since grant, field = captured select.
   int m_owner, m_age, m_field, m_last;
   bit m_rel, m_rel_to;

   always @(posedge clk or posedge reset) begin
      logic req, dn, sl;
      if (reset) begin
         m_owner = 0; m_age = 0; m_field = 0; m_last = 2; m_rel = 0; m_rel_to = 0;
      end else if (m_rel) begin
         m_rel = 0; m_rel_to = 0;
      end else if (m_owner == 0) begin
         if (bus_if.m1_request || bus_if.m2_request) begin
            if (bus_if.m1_request && bus_if.m2_request) m_owner = (m_last == 1) ? 2 : 1;
            else m_owner = bus_if.m1_request ? 1 : 2;
            m_age = 0; m_field = 0;
         end
      end else begin
         req = (m_owner == 1) ? bus_if.m1_request      : bus_if.m2_request;
         dn  = (m_owner == 1) ? bus_if.m1_done         : bus_if.m2_done;
         sl  = (m_owner == 1) ? bus_if.m1_slave_select : bus_if.m2_slave_select;
         if (!req || dn) begin
            m_rel = 1; m_rel_to = 0; m_last = m_owner; m_owner = 0;
         end else if (m_age <= SL) begin
            if (m_age >= 1) m_field = m_field * 2 + int'(sl);
            m_age++;
         end else if (m_age - SL - 1 == TO - 1) begin
            m_rel = 1; m_rel_to = 1; m_last = m_owner; m_owner = 0;
         end else begin
            m_age++;
         end
      end
   end

   function automatic logic [3:0] exp_slave_en();
      return (m_owner != 0 && m_age > SL) ? 4'(1 << m_field) : 4'd0;
   endfunction

   always @(negedge clk) begin
      check("m1_grant",   32'(bus_if.m1_grant),   32'(m_owner == 1));
      check("m2_grant",   32'(bus_if.m2_grant),   32'(m_owner == 2));
      check("busy",       32'(bus_if.busy),       32'(m_owner != 0));
      check("master_sel", 32'(bus_if.master_sel), 32'(m_owner == 2));
      check("slave_en",   32'(bus_if.slave_en),   32'(exp_slave_en()));
      check("timeout",    32'(bus_if.timeout),    32'(m_rel && m_rel_to));
      check("single_grant", 32'(bus_if.m1_grant & bus_if.m2_grant), 32'd0);
      check("slave_onehot", 32'($countones(bus_if.slave_en) <= 1), 32'd1);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus_if.m1_request = 0; bus_if.m2_request = 0;
      bus_if.m1_slave_select = 0; bus_if.m2_slave_select = 0;
      bus_if.m1_done = 0; bus_if.m2_done = 0;
   endtask

   // Leaves the bench at a negedge with reset just released: that negedge is cycle 0.
   task automatic do_reset();
      reset = 1; clear_inputs();
      tick(2);
      reset = 0;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_grant"},   32'({bus_if.m1_grant, bus_if.m2_grant}), 32'd0);
      check({name, "_busy"},    32'(bus_if.busy), 32'd0);
      check({name, "_sel"},     32'(bus_if.master_sel), 32'd0);
      check({name, "_slv"},     32'(bus_if.slave_en), 32'd0);
      check({name, "_timeout"}, 32'(bus_if.timeout), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset = 1; clear_inputs();
      @(posedge clk);
      #1 check_all_zero("por");

      // Single requester, field 2'b10, done after a few ACTIVE cycles.
      do_reset();
      check_all_zero("t1_c0");
      bus_if.m1_request = 1;
      tick(); check("t1_grant_c1", 32'({bus_if.m1_grant, bus_if.busy}), 32'b11);
      tick(); bus_if.m1_slave_select = 1;
      tick(); bus_if.m1_slave_select = 0; check("t1_slv_c3", 32'(bus_if.slave_en), 32'd0);
      tick(); check("t1_slv_c4", 32'(bus_if.slave_en), 32'b0100);
      check("t1_model_slv", 32'(exp_slave_en()), 32'b0100);
      tick(4); bus_if.m1_done = 1;
      tick(); bus_if.m1_done = 0; bus_if.m1_request = 0; check_all_zero("t1_c9");
      tick(); check_all_zero("t1_c10");

      // Contention: master 1, then master 2, then master 1 again.
      do_reset();
      bus_if.m1_request = 1; bus_if.m2_request = 1;
      tick(); check("t2_first_m1", 32'({bus_if.m1_grant, bus_if.master_sel}), 32'b10);
      tick(4); bus_if.m1_done = 1;
      tick(); bus_if.m1_done = 0; check("t2_rel1_busy", 32'(bus_if.busy), 32'd0);
      tick(); check("t2_idle1_busy", 32'(bus_if.busy), 32'd0);
      tick(); check("t2_then_m2", 32'({bus_if.m2_grant, bus_if.master_sel}), 32'b11);
      check("t2_model_owner", 32'(m_owner), 32'd2);
      tick(4); bus_if.m2_done = 1;
      tick(); bus_if.m2_done = 0; check("t2_rel2_busy", 32'(bus_if.busy), 32'd0);
      tick(2); check("t2_back_m1", 32'({bus_if.m1_grant, bus_if.master_sel}), 32'b10);
      bus_if.m1_request = 0; bus_if.m2_request = 0;
      tick(3);

      // Watchdog: ACTIVE cycles 4..11, pulse in cycle 12.
      do_reset();
      bus_if.m1_request = 1;
      tick(11); check("t3_c11", 32'({bus_if.m1_grant, bus_if.timeout}), 32'b10);
      tick(); bus_if.m1_request = 0;
      check("t3_pulse", 32'({bus_if.m1_grant, bus_if.busy, bus_if.timeout}), 32'b001);
      tick(); check_all_zero("t3_after");
      // Done on the 8th ACTIVE cycle beats the watchdog.
      tick(); bus_if.m1_request = 1;
      tick(11); bus_if.m1_done = 1;
      tick(); bus_if.m1_done = 0; bus_if.m1_request = 0; check_all_zero("t3_done_wins");
      tick(2);

      // Owner withdraws during SELECT.
      do_reset();
      bus_if.m1_request = 1;
      tick(2); bus_if.m1_request = 0;
      tick(); check_all_zero("t4_rel");
      tick(); check_all_zero("t4_idle");

      // Async reset between edges mid-ACTIVE.
      do_reset();
      bus_if.m1_request = 1;
      tick(5); check("t5_active", 32'({bus_if.m1_grant, bus_if.slave_en}), 32'b1_0001);
      #2 reset = 1; bus_if.m2_request = 1;
      #1 check_all_zero("t5_async");
      tick(); reset = 0;
      tick(); check("t5_m1_wins", 32'({bus_if.m1_grant, bus_if.m2_grant}), 32'b10);
      bus_if.m1_request = 0; bus_if.m2_request = 0;
      tick(3);

      // Non-owner done is ignored; its request stays pending.
      do_reset();
      bus_if.m1_request = 1;
      tick(4); bus_if.m2_request = 1; bus_if.m2_done = 1;
      tick(); bus_if.m2_done = 0;
      check("t6_keep", 32'({bus_if.m1_grant, bus_if.m2_grant, bus_if.slave_en}), 32'b10_0001);
      tick(); check("t6_keep2", 32'(bus_if.m1_grant), 32'd1); bus_if.m1_done = 1;
      tick(); bus_if.m1_done = 0; bus_if.m1_request = 0;
      tick(2); check("t6_pending_m2", 32'({bus_if.m2_grant, bus_if.master_sel}), 32'b11);
      bus_if.m2_request = 0;
      tick(3);

      // Randomized traffic with occasional asynchronous reset.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         tick();
         if ($urandom_range(0, 9) == 0) bus_if.m1_request = ~bus_if.m1_request;
         if ($urandom_range(0, 9) == 0) bus_if.m2_request = ~bus_if.m2_request;
         bus_if.m1_done = ($urandom_range(0, 15) == 0);
         bus_if.m2_done = ($urandom_range(0, 15) == 0);
         bus_if.m1_slave_select = 1'($urandom);
         bus_if.m2_slave_select = 1'($urandom);
         if ($urandom_range(0, 799) == 0) begin
            #2 reset = 1;
            #1 check_all_zero("rnd_async");
            tick(); reset = 0;
         end
      end
      clear_inputs();
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
